// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline sequencing controller for the 5-stage RV32I core. It decodes the
// instructions sitting in ID, EX, MEM and WB and produces the stage enables and
// clears. It also produces the ID-stage forwarding select used to resolve JALR
// targets early.
//
// Cycle priority: data-memory freeze > mispredict flush > hazard stall > normal.
//
// Parameters:
//   FLUSH_DEPTH  extra cycles (0..7) after the mispredict cycle during which
//                the ID->EX register keeps being cleared
//   CNT_W        width of the stall / flush performance counters
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   dec_inst          instruction being decoded in ID
//   ex_inst           instruction in EX
//   mem_inst          instruction in MEM
//   wb_inst           instruction in WB
//   ex_br_mispredict  EX resolved a mispredicted branch/jump this cycle
//   mem_stall_req     data memory not ready (held until ready)
//   pc_we             PC update enable
//   id_reg_we/_rst    ID->EX register enable / clear
//   ex_reg_we/_rst    EX->MEM register enable / clear
//   mem_reg_we/_rst   MEM->WB register enable / clear
//   jalr_fwd_sel      JALR rs1 source: 0 regfile, 1 EX alu, 2 MEM alu, 3 WB data
//   stall_cnt         number of stalled (frozen or hazard) cycles
//   flush_cnt         number of applied mispredict flushes
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      dec_inst,
  input  logic [31:0]      ex_inst,
  input  logic [31:0]      mem_inst,
  input  logic [31:0]      wb_inst,
  input  logic             ex_br_mispredict,
  input  logic             mem_stall_req,
  output logic             pc_we,
  output logic             id_reg_we,
  output logic             id_reg_rst,
  output logic             ex_reg_we,
  output logic             ex_reg_rst,
  output logic             mem_reg_we,
  output logic             mem_reg_rst,
  output logic [1:0]       jalr_fwd_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Value loaded into the flush down-counter; FLUSH is unreachable when the
  // depth is zero, so the load value is irrelevant in that case.
  localparam logic [2:0] FCNT_LOAD = (FLUSH_DEPTH > 0) ? 3'(FLUSH_DEPTH - 1) : 3'd0;
  localparam bit         HAS_FLUSH = (FLUSH_DEPTH > 0);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       fcnt_reg, fcnt_next;
  logic             pend_flush_reg, pend_flush_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  // ---------------------------------------------------------------------------
  // ID-stage decode
  // ---------------------------------------------------------------------------
  logic [6:0] dec_opc;
  logic [4:0] dec_rs1, dec_rs2;
  logic       dec_uses_rs1, dec_uses_rs2, dec_is_jalr;

  assign dec_opc      = dec_inst[6:0];
  assign dec_rs1      = dec_inst[19:15];
  assign dec_rs2      = dec_inst[24:20];
  assign dec_uses_rs1 = !((dec_opc == OPC_LUI) || (dec_opc == OPC_AUIPC) ||
                          (dec_opc == OPC_JAL));
  assign dec_uses_rs2 = (dec_opc == OPC_OP) || (dec_opc == OPC_BRANCH) ||
                        (dec_opc == OPC_STORE);
  assign dec_is_jalr  = (dec_opc == OPC_JALR);

  // ---------------------------------------------------------------------------
  // Producer-stage decode: index 1 = EX, 2 = MEM, 3 = WB
  // ---------------------------------------------------------------------------
  logic [31:0] stage_inst [1:3];
  logic [4:0]  stage_rd   [1:3];
  logic [3:1]  stage_writer;
  logic [3:1]  stage_load;
  logic [3:1]  stage_hit_rs1;   // stage writes the register JALR/dec reads as rs1
  logic [3:1]  stage_fwd_ok;    // stage may serve as a JALR forwarding source

  assign stage_inst[1] = ex_inst;
  assign stage_inst[2] = mem_inst;
  assign stage_inst[3] = wb_inst;

  genvar gi;
  generate
    for (gi = 1; gi <= 3; gi++) begin : g_stage
      logic [6:0] opc;
      logic [2:0] funct3;
      logic       writes_op;

      assign opc          = stage_inst[gi][6:0];
      assign funct3       = stage_inst[gi][14:12];
      assign stage_rd[gi] = stage_inst[gi][11:7];

      always_comb begin
        writes_op = 1'b0;
        case (opc)
          OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
          OPC_OP, OPC_OPIMM, OPC_LOAD: writes_op = 1'b1;
          // CSR instructions write rd; ECALL/EBREAK (funct3 0) do not
          OPC_SYSTEM:                  writes_op = (funct3 != 3'd0);
          default:                     writes_op = 1'b0;
        endcase
      end

      // rd != 0 in the writer term keeps x0 from ever matching
      assign stage_writer[gi]  = writes_op && (stage_rd[gi] != 5'd0);
      assign stage_load[gi]    = (opc == OPC_LOAD);
      assign stage_hit_rs1[gi] = stage_writer[gi] && (stage_rd[gi] == dec_rs1);
      // A load result is only available once it reaches WB
      assign stage_fwd_ok[gi]  = (gi == 3) || !stage_load[gi];
    end
  endgenerate

  logic ex_hit_rs2;
  assign ex_hit_rs2 = stage_writer[1] && (stage_rd[1] == dec_rs2);

  // Fields that no decision depends on
  logic unused_inst_bits;
  assign unused_inst_bits = ^{dec_inst[31:25], dec_inst[14:7],
                              ex_inst[31:15], mem_inst[31:15], wb_inst[31:15]};

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic load_use, jalr_haz;

  assign load_use = stage_load[1] &&
                    ((dec_uses_rs1 && stage_hit_rs1[1]) ||
                     (dec_uses_rs2 && ex_hit_rs2));

  // JALR reads rs1 in ID, so it must wait until a load writing it reaches WB
  assign jalr_haz = dec_is_jalr &&
                    ((stage_load[1] && stage_hit_rs1[1]) ||
                     (stage_load[2] && stage_hit_rs1[2]));

  logic [1:0] fwd_sel;
  always_comb begin
    fwd_sel = 2'd0;
    if (stage_fwd_ok[1] && stage_hit_rs1[1])      fwd_sel = 2'd1;
    else if (stage_fwd_ok[2] && stage_hit_rs1[2]) fwd_sel = 2'd2;
    else if (stage_fwd_ok[3] && stage_hit_rs1[3]) fwd_sel = 2'd3;
  end

  // ---------------------------------------------------------------------------
  // Cycle classification (mutually exclusive, in priority order)
  // ---------------------------------------------------------------------------
  logic freeze, flush_apply, flush_hold, hazard_stall;

  assign freeze       = mem_stall_req;
  // A flush deferred by a freeze is applied on the first unfrozen cycle;
  // pend_flush can only be set while frozen, so this is uniform across states.
  assign flush_apply  = !mem_stall_req && (ex_br_mispredict || pend_flush_reg);
  assign flush_hold   = !mem_stall_req && !flush_apply && (state_reg == ST_FLUSH);
  assign hazard_stall = !mem_stall_req && !flush_apply && (state_reg != ST_FLUSH) &&
                        (load_use || jalr_haz);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_RUN;
      fcnt_reg       <= 3'd0;
      pend_flush_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fcnt_reg       <= fcnt_next;
      pend_flush_reg <= pend_flush_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    fcnt_next       = fcnt_reg;
    pend_flush_next = pend_flush_reg;

    if (freeze) begin
      // Remember a mispredict seen while frozen; FLUSH keeps its count
      pend_flush_next = pend_flush_reg | ex_br_mispredict;
      if (state_reg == ST_RUN) state_next = ST_MEM_WAIT;
    end else if (flush_apply) begin
      pend_flush_next = 1'b0;
      if (HAS_FLUSH) begin
        state_next = ST_FLUSH;
        fcnt_next  = FCNT_LOAD;
      end else begin
        state_next = ST_RUN;
      end
    end else if (state_reg == ST_FLUSH) begin
      if (fcnt_reg == 3'd0) state_next = ST_RUN;
      else                  fcnt_next  = fcnt_reg - 3'd1;
    end else begin
      state_next = ST_RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_we        = 1'b1;
    id_reg_we    = 1'b1;
    id_reg_rst   = 1'b0;
    ex_reg_we    = 1'b1;
    ex_reg_rst   = 1'b0;
    mem_reg_we   = 1'b1;
    mem_reg_rst  = 1'b0;
    jalr_fwd_sel = fwd_sel;

    if (rst) begin
      pc_we        = 1'b0;
      id_reg_we    = 1'b0;
      id_reg_rst   = 1'b1;
      ex_reg_we    = 1'b0;
      ex_reg_rst   = 1'b1;
      mem_reg_we   = 1'b0;
      mem_reg_rst  = 1'b1;
      jalr_fwd_sel = 2'd0;
    end else if (freeze) begin
      // Hold everything upstream; WB gets a bubble so the instruction in MEM
      // is not written back twice.
      pc_we       = 1'b0;
      id_reg_we   = 1'b0;
      ex_reg_we   = 1'b0;
      mem_reg_we  = 1'b0;
      mem_reg_rst = 1'b1;
    end else if (flush_apply || flush_hold) begin
      // PC loads the redirect target / keeps fetching; ID is squashed
      id_reg_rst = 1'b1;
    end else if (hazard_stall) begin
      pc_we      = 1'b0;
      id_reg_rst = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters (wrap naturally)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (freeze || hazard_stall) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_apply)            flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32I core. It decodes the instructions in the ID, EX, MEM and WB stages and produces the PC, ID, EX and MEM stage enables and resets. It also drives the ID-stage forwarding select used for JALR target resolution. It detects load-use and JALR hazards, freezes the pipe on data-memory wait, and sequences multi-cycle flushes on branch mispredict. It keeps stall and flush performance counters for CSR readout.

Parameters:
FLUSH_DEPTH, 1, extra cycles after the mispredict cycle during which id_reg_rst stays asserted (0..7)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dec_inst  in  32  instruction currently being decoded in ID
ex_inst  in  32  instruction in EX
mem_inst  in  32  instruction in MEM
wb_inst  in  32  instruction in WB
ex_br_mispredict  in  1  EX resolved a mispredicted branch/jump this cycle
mem_stall_req  in  1  data memory not ready; held high until ready
pc_we  out  1  PC register update enable
id_reg_we  out  1  ID->EX pipeline register enable
id_reg_rst  out  1  ID->EX register clear (inject bubble)
ex_reg_we  out  1  EX->MEM enable
ex_reg_rst  out  1  EX->MEM clear
mem_reg_we  out  1  MEM->WB enable
mem_reg_rst  out  1  MEM->WB clear
jalr_fwd_sel  out  2  0 regfile, 1 ex_alu, 2 mem_alu, 3 wb_wdata
stall_cnt  out  CNT_W  stalled cycles
flush_cnt  out  CNT_W  mispredict events

Behaviour:
- Clock port is clk. Reset port is rst, synchronous and active-high.
- Decode rules:
  - Writer: opcode LUI, AUIPC, JAL, JALR, OP, OP-IMM, LOAD, or SYSTEM with funct3!=0; rd!=0.
  - Uses rs1: every opcode except LUI, AUIPC, JAL.
  - Uses rs2: OP, BRANCH, STORE.
  - x0 never matches.
- Outputs are combinational from state, pend_flush and the current inputs. State and counters are registered.
- rst=1 forces:
  - state RUN, pend_flush=0, counters 0.
  - Outputs: all *_we=0, all *_rst=1, jalr_fwd_sel=0.
- States: RUN, MEM_WAIT, FLUSH. Priority within a cycle: freeze > flush > hazard stall > normal.
- Freeze (mem_stall_req=1, any state):
  - pc_we, id_reg_we, ex_reg_we all 0; id_reg_rst and ex_reg_rst 0.
  - mem_reg_rst=1, so WB receives a bubble and no double write occurs.
  - stall_cnt increments.
  - pend_flush |= ex_br_mispredict.
  - From RUN, go to MEM_WAIT. In FLUSH, stay in FLUSH and hold the flush counter.
- MEM_WAIT with mem_stall_req=0:
  - If pend_flush: apply a flush this cycle and clear pend_flush.
  - Otherwise: evaluate as RUN.
  - Next state is RUN, or FLUSH if a flush was applied and FLUSH_DEPTH>0.
- Flush (mispredict in RUN/FLUSH, or pending flush released):
  - pc_we=1 (datapath loads the target), id_reg_rst=1, all other we=1.
  - flush_cnt increments by 1 per event.
  - If FLUSH_DEPTH>0: load fcnt=FLUSH_DEPTH-1 and go to FLUSH. Otherwise stay in RUN.
- FLUSH state:
  - id_reg_rst=1, pc_we=1, ex/mem advance.
  - If fcnt==0 go to RUN, else fcnt decrements.
  - A mispredict in FLUSH reloads fcnt and counts again.
- Load-use stall (RUN):
  - Condition: ex_inst is LOAD writer, and ex rd equals a used rs of dec_inst.
  - Action: pc_we=0, id_reg_rst=1, ex/mem advance, stall_cnt+1. Exactly one cycle per hazard.
- JALR stall (RUN):
  - Condition: dec_inst is JALR, and a LOAD in EX or MEM writes its rs1.
  - Action: same as load-use; repeats until the load reaches WB.
- jalr_fwd_sel:
  - Checks the first non-load writer with rd==dec rs1, in priority EX(1), MEM(2), WB(3); WB qualifies for loads too. If none match, the value is 0.
  - The value is meaningful only when dec_inst is JALR; otherwise it is still computed but unused.
- Counters wrap at 2^CNT_W.

Test Plan:
- Reset 3 cycles then release, no hazards (dec ADDI x1,x0,5; ex NOP) → cycle after release: pc_we=1, all we=1, all rst=0, counters 0.
- ex LW x5,0(x2), dec ADD x6,x5,x7 → one cycle pc_we=0, id_reg_rst=1, stall_cnt=1. Next cycle (ex=bubble) → normal.
- dec JALR x0,0(x5), mem LW x5 → stall. Then wb LW x5 → no stall, jalr_fwd_sel=3. Separately, ex ADDI x5 with mem ADDI x5 → jalr_fwd_sel=1.
- FLUSH_DEPTH=1, ex_br_mispredict pulse → id_reg_rst=1 for 2 cycles, flush_cnt=1, pc_we=1 both cycles.
- mem_stall_req high for 4 cycles, with ex_br_mispredict pulsed in cycle 2 → 4 frozen cycles with mem_reg_rst=1. On release: flush applied, flush_cnt=1, stall_cnt=4.
- Assert rst during FLUSH and during MEM_WAIT → next cycle state RUN, pend_flush cleared, counters 0.
